writeback_queue: RTL

Write-side front end for the CPU register file. Accepts register writeback results from the ALU and the load unit over valid/ready handshakes, buffers them in a small in-order queue, and drains exactly one entry per cycle onto the register file's single write port. Optionally supplies forwarding data for RS/RT operand addresses whose writes are still queued.

---
 rtl/wb_pkg.sv | 20 ++
 rtl/writeback_queue_if.sv | 53 +++++
 rtl/wb_fifo.sv | 53 +++++
 rtl/writeback_queue.sv | 113 +++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and sizing for the register-file writeback queue.
package wb_pkg;

    localparam int WB_DATA_WIDTH = 32;
    localparam int WB_ADDR_WIDTH = 5;
    localparam int WB_DEPTH      = 4;

    // Occupancy counters must represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int WB_CNT_WIDTH = cnt_width(WB_DEPTH);

    typedef struct packed {
        logic [WB_ADDR_WIDTH-1:0] addr;
        logic [WB_DATA_WIDTH-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/writeback_queue_if.sv
// Producer handshakes, register-file write port, forwarding lookup and status
// of the writeback queue. The CPU side uses master, the queue uses slave.
interface writeback_queue_if
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH     = WB_DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int CNT_WIDTH      = WB_CNT_WIDTH
);
    logic                      i_Alu_Valid;
    logic                      o_Alu_Ready;
    logic [REG_ADDR_WIDTH-1:0] i_Alu_Addr;
    logic [DATA_WIDTH-1:0]     i_Alu_Data;

    logic                      i_Mem_Valid;
    logic                      o_Mem_Ready;
    logic [REG_ADDR_WIDTH-1:0] i_Mem_Addr;
    logic [DATA_WIDTH-1:0]     i_Mem_Data;

    logic                      o_Write_Enable;
    logic [REG_ADDR_WIDTH-1:0] o_Write_Addr;
    logic [DATA_WIDTH-1:0]     o_Write_Data;

    logic [REG_ADDR_WIDTH-1:0] i_RS_Addr;
    logic [REG_ADDR_WIDTH-1:0] i_RT_Addr;
    logic                      o_RS_Hit;
    logic                      o_RT_Hit;
    logic [DATA_WIDTH-1:0]     o_RS_Fwd_Data;
    logic [DATA_WIDTH-1:0]     o_RT_Fwd_Data;

    logic [CNT_WIDTH-1:0]      o_Count;
    logic                      o_Empty;

    modport master (
        output i_Alu_Valid, i_Alu_Addr, i_Alu_Data,
        output i_Mem_Valid, i_Mem_Addr, i_Mem_Data,
        output i_RS_Addr, i_RT_Addr,
        input  o_Alu_Ready, o_Mem_Ready,
        input  o_Write_Enable, o_Write_Addr, o_Write_Data,
        input  o_RS_Hit, o_RT_Hit, o_RS_Fwd_Data, o_RT_Fwd_Data,
        input  o_Count, o_Empty
    );

    modport slave (
        input  i_Alu_Valid, i_Alu_Addr, i_Alu_Data,
        input  i_Mem_Valid, i_Mem_Addr, i_Mem_Data,
        input  i_RS_Addr, i_RT_Addr,
        output o_Alu_Ready, o_Mem_Ready,
        output o_Write_Enable, o_Write_Addr, o_Write_Data,
        output o_RS_Hit, o_RT_Hit, o_RS_Fwd_Data, o_RT_Fwd_Data,
        output o_Count, o_Empty
    );
endinterface

// File: rtl/wb_fifo.sv
// Circular buffer with two ordered pushes and one pop per cycle; exposes the
// whole entry array and head pointer so the owner can search stored entries.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int  DEPTH   = WB_DEPTH,
    parameter type entry_t = wb_entry_t,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = PTR_W + 1
) (
    input  logic             i_Clk,
    input  logic             i_Reset_n,
    input  logic             push_first,
    input  entry_t           first_entry,
    input  logic             push_second,
    input  entry_t           second_entry,
    input  logic             pop,
    output logic [PTR_W-1:0] head_ptr,
    output logic [CNT_W-1:0] count,
    output entry_t           entries [DEPTH]
);
    logic [PTR_W-1:0] tail_ptr;
    logic [PTR_W-1:0] second_slot;
    logic             do_pop;

    assign do_pop      = pop && (count != '0);
    // The second push lands behind the first one when both fire together.
    assign second_slot = tail_ptr + PTR_W'(push_first);

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            head_ptr <= head_ptr + PTR_W'(do_pop);
            tail_ptr <= tail_ptr + PTR_W'(push_first) + PTR_W'(push_second);
            count    <= count - CNT_W'(do_pop) + CNT_W'(push_first) + CNT_W'(push_second);
        end
    end

    // NOTE: storage is deliberately not reset; count alone says which slots are live.
    always_ff @(posedge i_Clk) begin
        if (push_first) begin
            entries[tail_ptr] <= first_entry;
        end
        if (push_second) begin
            entries[second_slot] <= second_entry;
        end
    end

endmodule

// File: rtl/writeback_queue.sv
// Register-file writeback queue: ALU/load handshakes, r0 filtering, one drain
// per cycle and optional operand forwarding (enabled by WB_FORWARD_EN).
module writeback_queue
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH     = WB_DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int DEPTH          = WB_DEPTH
) (
    input logic              i_Clk,
    input logic              i_Reset_n,
    writeback_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]     data;
    } entry_t;

    entry_t           alu_entry;
    entry_t           mem_entry;
    entry_t           head_entry;
    entry_t           entries [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] free;
    logic             not_empty;
    logic             alu_ready;
    logic             mem_ready;
    logic             alu_push;
    logic             mem_push;

    assign not_empty = (count != '0);
    // The head pop on the same edge frees one slot for an incoming entry.
    assign free      = CNT_W'(DEPTH) - count + CNT_W'(not_empty);
    assign alu_ready = (free >= CNT_W'(1));
    assign mem_ready = (free >= CNT_W'(2)) || (alu_ready && !bus.i_Alu_Valid);

    // r0 writes complete the handshake but never occupy a slot.
    assign alu_push  = bus.i_Alu_Valid && alu_ready && (bus.i_Alu_Addr != '0);
    assign mem_push  = bus.i_Mem_Valid && mem_ready && (bus.i_Mem_Addr != '0);
    assign alu_entry = '{addr: bus.i_Alu_Addr, data: bus.i_Alu_Data};
    assign mem_entry = '{addr: bus.i_Mem_Addr, data: bus.i_Mem_Data};

    wb_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .i_Clk        (i_Clk),
        .i_Reset_n    (i_Reset_n),
        .push_first   (alu_push),
        .first_entry  (alu_entry),
        .push_second  (mem_push),
        .second_entry (mem_entry),
        .pop          (not_empty),
        .head_ptr     (head_ptr),
        .count        (count),
        .entries      (entries)
    );

    assign head_entry         = entries[head_ptr];
    assign bus.o_Alu_Ready    = alu_ready;
    assign bus.o_Mem_Ready    = mem_ready;
    assign bus.o_Write_Enable = not_empty;
    assign bus.o_Write_Addr   = not_empty ? head_entry.addr : '0;
    assign bus.o_Write_Data   = not_empty ? head_entry.data : '0;
    assign bus.o_Count        = count;
    assign bus.o_Empty        = !not_empty;

`ifdef WB_FORWARD_EN
    logic [PTR_W-1:0]      slot;
    logic                  rs_hit;
    logic                  rt_hit;
    logic [DATA_WIDTH-1:0] rs_data;
    logic [DATA_WIDTH-1:0] rt_data;

    // Walk from oldest to youngest so the youngest match overwrites earlier ones.
    // NOTE: defaults first keep this block free of inferred latches.
    always_comb begin
        slot    = '0;
        rs_hit  = 1'b0;
        rt_hit  = 1'b0;
        rs_data = '0;
        rt_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot = head_ptr + PTR_W'(k);
            if (CNT_W'(k) < count) begin
                if ((bus.i_RS_Addr != '0) && (entries[slot].addr == bus.i_RS_Addr)) begin
                    rs_hit  = 1'b1;
                    rs_data = entries[slot].data;
                end
                if ((bus.i_RT_Addr != '0) && (entries[slot].addr == bus.i_RT_Addr)) begin
                    rt_hit  = 1'b1;
                    rt_data = entries[slot].data;
                end
            end
        end
    end

    assign bus.o_RS_Hit      = rs_hit;
    assign bus.o_RT_Hit      = rt_hit;
    assign bus.o_RS_Fwd_Data = rs_data;
    assign bus.o_RT_Fwd_Data = rt_data;
`else
    assign bus.o_RS_Hit      = 1'b0;
    assign bus.o_RT_Hit      = 1'b0;
    assign bus.o_RS_Fwd_Data = '0;
    assign bus.o_RT_Fwd_Data = '0;
`endif

endmodule
